// File: rtl/fp_operand_fetch.sv
// fp_operand_fetch: reads A/B FP16 operand pairs from a word SRAM and presents them to a MAC.
// Define FETCH_ZERO_SKIP_EN to drop pairs where either operand is +/-0.
module fp_operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  base_a,
    input  logic [3:0]  base_b,
    input  logic [4:0]  len,
    output logic        sram_cs,
    output logic        sram_we,
    output logic        sram_oe,
    output logic [3:0]  sram_addr,
    input  logic [15:0] sram_dout,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        op_last,
    output logic        busy,
    output logic        done
);
    localparam logic [2:0] st_idle = 3'd0, st_rd_a = 3'd1, st_rd_b = 3'd2, st_present = 3'd3, st_done = 3'd4;
    logic [2:0] state;
    logic [3:0] i, ba, bb, addr_q;
    logic [4:0] ln;
    logic       last, skip, rd;
    assign rd = (state == st_rd_a) || (state == st_rd_b);
    assign last = ({1'b0, i} == ln - 5'd1);
    // the address is held between reads so the SRAM bus stays quiet
    assign sram_addr = (state == st_rd_a) ? ba + i : (state == st_rd_b) ? bb + i : addr_q;
    assign sram_cs = !rd;
    assign sram_oe = !rd;
    assign sram_we = 1'b1;
    assign op_valid = (state == st_present);
    assign op_last = op_valid && last;
    assign busy = (state != st_idle);
    assign done = (state == st_done);
`ifdef FETCH_ZERO_SKIP_EN
    assign skip = (op_a[14:0] == 15'd0) || (sram_dout[14:0] == 15'd0);
`else
    assign skip = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= st_idle;
            i <= 4'd0;
            ba <= 4'd0;
            bb <= 4'd0;
            ln <= 5'd0;
            addr_q <= 4'd0;
            op_a <= 16'd0;
            op_b <= 16'd0;
        end else begin
            addr_q <= sram_addr;
            case (state)
                st_idle: if (start) begin
                    if (len == 5'd0) state <= st_done;
                    else begin
                        i <= 4'd0;
                        ba <= base_a;
                        bb <= base_b;
                        ln <= len;
                        state <= st_rd_a;
                    end
                end
                st_rd_a: begin
                    op_a <= sram_dout;
                    state <= st_rd_b;
                end
                st_rd_b: begin
                    op_b <= sram_dout;
                    if (!skip) state <= st_present;
                    else if (last) state <= st_done;
                    else begin
                        i <= i + 4'd1;
                        state <= st_rd_a;
                    end
                end
                st_present: if (op_ready) begin
                    if (last) state <= st_done;
                    else begin
                        i <= i + 4'd1;
                        state <= st_rd_a;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_operand_fetch.sv
// tb_fp_operand_fetch: random and directed fetch runs checked against a pair-list model of the SRAM walk.
module tb_fp_operand_fetch;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, op_ready = 1'b0;
    logic [3:0]  base_a = 4'd0, base_b = 4'd0, sram_addr;
    logic [4:0]  len = 5'd0;
    logic        sram_cs, sram_we, sram_oe, op_valid, op_last, busy, done;
    logic [15:0] sram_dout, op_a, op_b;
    logic [15:0] mem [16];
    int          n_chk = 0, n_pass = 0;
`ifdef FETCH_ZERO_SKIP_EN
    localparam bit zs = 1'b1;
`else
    localparam bit zs = 1'b0;
`endif

    fp_operand_fetch dut (
        .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b), .len(len),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe), .sram_addr(sram_addr),
        .sram_dout(sram_dout), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
        .op_ready(op_ready), .op_last(op_last), .busy(busy), .done(done)
    );

    assign sram_dout = mem[sram_addr];
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {sram_cs, sram_we, sram_oe}, 3'b111);
        check({tag, "_addr"}, sram_addr, 4'd0);
        check({tag, "_ops"}, {op_a, op_b}, 32'd0);
        check({tag, "_flags"}, {op_valid, op_last, busy, done}, 4'b0000);
    endtask

    // One run: the expected pair k is (mem[ba+k], mem[bb+k]) with 4-bit wrap,
    // read over two cycles and then presented until accepted.
    task automatic run(input logic [3:0] ba, input logic [3:0] bb, input logic [4:0] l, input int stall);
        logic [3:0]  aa, ab;
        logic [15:0] ea, eb;
        logic        rdy;
        int          waits;
        @(negedge clk);
        start = 1'b1; base_a = ba; base_b = bb; len = l; op_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < l; k++) begin
            aa = ba + 4'(k);
            ab = bb + 4'(k);
            ea = mem[aa];
            eb = mem[ab];
            check("rd_a_ctl", {sram_cs, sram_we, sram_oe, op_valid, busy}, 5'b01001);
            check("rd_a_addr", sram_addr, aa);
            @(negedge clk);
            check("rd_b_ctl", {sram_cs, sram_we, sram_oe, op_valid, busy}, 5'b01001);
            check("rd_b_addr", sram_addr, ab);
            @(negedge clk);
            if (zs && (ea[14:0] == 15'd0 || eb[14:0] == 15'd0)) continue;
            waits = 0;
            forever begin
                check("pres_valid", {op_valid, op_last}, {1'b1, k == l - 1});
                check("pres_ops", {op_a, op_b}, {ea, eb});
                check("pres_bus", {sram_cs, sram_oe, sram_addr}, {2'b11, ab});
                rdy = (k == 0 && stall > 0) ? (waits >= stall) : ($urandom_range(0, 2) != 0 || waits >= 4);
                op_ready = rdy;
                @(negedge clk);
                op_ready = 1'b0;
                waits++;
                if (rdy) break;
            end
        end
        check("done_pulse", {done, busy, op_valid, sram_cs}, 4'b1101);
        @(negedge clk);
        check("done_end", {done, busy}, 2'b00);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 16'(k * 16'h0111);
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        // straight three-pair run, MAC always ready
        mem[1] = 16'h3c00; mem[2] = 16'h4000; mem[3] = 16'h4200; mem[4] = 16'h4400;
        run(4'd1, 4'd2, 5'd3, 0);
        // same run with the first pair stalled for 4 cycles
        run(4'd1, 4'd2, 5'd3, 4);
        // reset in the middle of the B read
        @(negedge clk);
        start = 1'b1; base_a = 4'd1; base_b = 4'd2; len = 5'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_addr", sram_addr, 4'd2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst", {done, busy}, 2'b00);
        end
        // wrap-around addresses
        mem[0] = 16'h0000; mem[14] = 16'h4b00; mem[15] = 16'h4b80;
        run(4'd15, 4'd14, 5'd2, 0);
        // empty run: done only, bus untouched
        @(negedge clk);
        start = 1'b1; len = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", {done, busy, op_valid, sram_cs}, 4'b1101);
        @(negedge clk);
        check("len0_end", {done, busy, op_valid, sram_cs}, 4'b0001);
`ifdef FETCH_ZERO_SKIP_EN
        mem[0] = 16'h0000; mem[1] = 16'h3c00; mem[2] = 16'h4000;
        run(4'd0, 4'd1, 5'd2, 0);
`endif
        // randomized runs, including occasional signed zeros
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 16; k++)
                mem[k] = ($urandom_range(0, 5) == 0) ? {1'($urandom_range(0, 1)), 15'd0} : 16'($urandom);
            run(4'($urandom), 4'($urandom), 5'($urandom_range(0, 16)), ($urandom_range(0, 3) == 0) ? 3 : 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_operand_fetch.md
FP_OPERAND_FETCH -- requirements
Module: fp_operand_fetch

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a fetch run; sampled in IDLE only.
- base_a  in  4  SRAM word address of the first A operand.
- base_b  in  4  SRAM word address of the first B operand.
- len  in  5  number of operand pairs, 0..16.
- sram_cs  out  1  SRAM chip select, active-low.
- sram_we  out  1  SRAM write enable, active-low.
- sram_oe  out  1  SRAM output enable, active-low.
- sram_addr  out  4  SRAM word address.
- sram_dout  in  16  SRAM read data (FP16), combinational from sram_addr.
- op_a  out  16  FP16 operand A to the MAC.
- op_b  out  16  FP16 operand B to the MAC.
- op_valid  out  1  op_a/op_b hold a valid pair.
- op_ready  in  1  MAC accepts the pair.
- op_last  out  1  final pair of the run; qualified by op_valid.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at the end of a run.

Function
REQ-002 SHALL implement the FSM IDLE, RD_A, RD_B, PRESENT, DONE.
REQ-003 In IDLE with start=1: if len=0, SHALL go to DONE; otherwise SHALL clear the pair index i, latch base_a, base_b and len, and go to RD_A.
REQ-004 In RD_A, SHALL drive sram_cs=0, sram_we=1, sram_oe=0 and sram_addr=(base_a+i) mod 16, capture sram_dout into op_a at the edge, then go to RD_B.
REQ-005 In RD_B, SHALL drive the same controls with sram_addr=(base_b+i) mod 16, capture sram_dout into op_b at the edge, then go to PRESENT.
REQ-006 In all other states, SHALL drive sram_cs=1, sram_we=1, sram_oe=1 and hold sram_addr; sram_we SHALL never be 0.
REQ-007 In PRESENT, SHALL assert op_valid=1 and op_last=(i==len-1).
REQ-008 A transfer SHALL occur on an edge where op_valid and op_ready are both 1.
  - On a transfer with op_last=1: go to DONE.
  - On a transfer otherwise: increment i and go to RD_A.
REQ-009 While op_valid=1 and op_ready=0, op_a, op_b and op_last SHALL remain stable.
REQ-010 First op_valid SHALL assert 3 cycles after the start edge; pair throughput SHALL be at most one per 3 cycles.
REQ-011 In DONE, SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 start SHALL be ignored outside IDLE.
REQ-014 Address arithmetic SHALL be 4-bit and wrap mod 16.

Reset
REQ-015 rst=1 SHALL force IDLE immediately, regardless of clk, including mid-run.
REQ-016 Reset values SHALL be:
- sram_cs=1, sram_we=1, sram_oe=1, sram_addr=0.
- op_a=0, op_b=0, op_valid=0, op_last=0.
- busy=0, done=0, i=0.
REQ-017 No done pulse SHALL follow a reset-aborted run.

Configuration
REQ-018 SHALL define the macro FETCH_ZERO_SKIP_EN to enable zero-pair skipping.
- Defined: after RD_B, if op_a[14:0]==0 or the captured op_b[14:0]==0, PRESENT SHALL be skipped.
  - Skipped pair not last: go to RD_A with i+1.
  - Skipped pair last: go to DONE; op_last is never asserted for that run.
- Undefined: every pair SHALL be presented.

Verification
REQ-019 Reset assert mid-RD_B -> all outputs SHALL equal the REQ-016 values in the same cycle; no done pulse after release.
REQ-020 SRAM words 1..4 = 3c00, 4000, 4200, 4400; base_a=1, base_b=2, len=3, op_ready=1 -> pairs SHALL be (3c00,4000), (4000,4200), (4200,4400).
  - op_valid SHALL rise 3 cycles after start, with 3-cycle spacing between pairs.
  - op_last SHALL be 1 on the third pair; done SHALL pulse the cycle after it.
REQ-021 Same run with op_ready=0 for 4 cycles on the first pair -> op_a=3c00 and op_b=4000 SHALL hold; sram_cs SHALL stay 1; no address advance.
REQ-022 SRAM words 0, 14, 15 = 0000, 4b00, 4b80; base_a=15, base_b=14, len=2 -> pairs SHALL be (4b80,4b00), then (0000,4b80).
REQ-023 len=0 -> done SHALL pulse 1 cycle after start; op_valid SHALL stay 0; sram_cs SHALL stay 1.
REQ-024 With FETCH_ZERO_SKIP_EN, same SRAM as REQ-020 plus word 0 = 0000; base_a=0, base_b=1, len=2 -> only (3c00,4000) SHALL be presented, with op_last=1, followed by the done pulse.
